// File: rtl/m_axis_ex_if.sv
// AXI4-Stream master-side bundle for m_axis_ex: payload, sideband flags and handshake.
interface m_axis_ex_if #(
    parameter int C_M_AXIS_TDATA_WIDTH = 8
) ();
    logic                                tvalid;
    logic [C_M_AXIS_TDATA_WIDTH-1:0]     tdata;
    logic [(C_M_AXIS_TDATA_WIDTH/8)-1:0] tstrb;
    logic                                tlast;
    logic                                tuser;
    logic                                tready;

    modport master (
        output tvalid, tdata, tstrb, tlast, tuser,
        input  tready
    );

    modport slave (
        input  tvalid, tdata, tstrb, tlast, tuser,
        output tready
    );
endinterface

// File: rtl/m_axis_ex.sv
// Example AXI4-Stream master: waits a start delay after reset, then streams an
// incrementing count in frames of C_M_LINES lines of C_M_LINE_LEN beats each.
module m_axis_ex #(
    parameter int C_M_AXIS_TDATA_WIDTH = 8,
    parameter int C_M_START_COUNT      = 8,
    parameter int C_M_LINE_LEN         = 8,
    parameter int C_M_LINES            = 4
) (
    input  logic     M_AXIS_ACLK,
    input  logic     M_AXIS_ARESET,
    m_axis_ex_if.master M_AXIS
);
    localparam int TOTAL = C_M_LINE_LEN * C_M_LINES;
    localparam int BW    = (TOTAL > 1) ? $clog2(TOTAL) : 1;
    localparam int CW    = (C_M_LINE_LEN > 1) ? $clog2(C_M_LINE_LEN) : 1;
    localparam int SW    = (C_M_START_COUNT > 1) ? $clog2(C_M_START_COUNT) : 1;

    localparam logic [BW-1:0] B_LAST = BW'(TOTAL - 1);
    localparam logic [CW-1:0] C_LAST = CW'(C_M_LINE_LEN - 1);
    localparam logic [SW-1:0] S_LAST = SW'(C_M_START_COUNT - 1);

    typedef enum logic [1:0] {
        IDLE,
        INIT_COUNTER,
        SEND_STREAM
    } state_t;

    state_t        state_q;
    state_t        state_d;
    logic [SW-1:0] start_cnt;
    logic [BW-1:0] beat_q;
    logic [CW-1:0] col_q;
    logic          tvalid_q;
    logic          xfer;

    assign xfer = tvalid_q & M_AXIS.tready;

    always_comb begin
        state_d = state_q;
        unique case (state_q)
            IDLE:         state_d = INIT_COUNTER;
            INIT_COUNTER: if (start_cnt == S_LAST) state_d = SEND_STREAM;
            SEND_STREAM:  state_d = SEND_STREAM;
            default:      state_d = IDLE;
        endcase
    end

    // TVALID registers the next state so it rises on the edge entering SEND_STREAM.
    always_ff @(posedge M_AXIS_ACLK or posedge M_AXIS_ARESET) begin
        if (M_AXIS_ARESET) begin
            state_q   <= IDLE;
            start_cnt <= '0;
            tvalid_q  <= 1'b0;
        end else begin
            state_q   <= state_d;
            start_cnt <= (state_q == INIT_COUNTER) ? start_cnt + 1'b1 : '0;
            tvalid_q  <= (state_d == SEND_STREAM);
        end
    end

    always_ff @(posedge M_AXIS_ACLK or posedge M_AXIS_ARESET) begin
        if (M_AXIS_ARESET) begin
            beat_q <= '0;
            col_q  <= '0;
        end else if (xfer) begin
            beat_q <= (beat_q == B_LAST) ? '0 : beat_q + 1'b1;
            col_q  <= (col_q == C_LAST) ? '0 : col_q + 1'b1;
        end
    end

    assign M_AXIS.tvalid = tvalid_q;
    assign M_AXIS.tdata  = C_M_AXIS_TDATA_WIDTH'(beat_q);
    assign M_AXIS.tstrb  = {(C_M_AXIS_TDATA_WIDTH/8){tvalid_q}};
    assign M_AXIS.tuser  = tvalid_q && (beat_q == '0);
    assign M_AXIS.tlast  = tvalid_q && (col_q == C_LAST);
endmodule

// File: tb/tb_m_axis_ex.sv
// Directed bench for m_axis_ex: default 8x4 framing plus a 1x1 instance sharing clock/reset/ready.
module tb_m_axis_ex;
    logic clk;
    logic rst;
    int   checks;
    int   failures;
    int   exp_b;

    m_axis_ex_if #(.C_M_AXIS_TDATA_WIDTH(8)) axis ();
    m_axis_ex_if #(.C_M_AXIS_TDATA_WIDTH(8)) axis_min ();

    m_axis_ex #(
        .C_M_AXIS_TDATA_WIDTH(8),
        .C_M_START_COUNT(8),
        .C_M_LINE_LEN(8),
        .C_M_LINES(4)
    ) u_dut (
        .M_AXIS_ACLK(clk),
        .M_AXIS_ARESET(rst),
        .M_AXIS(axis.master)
    );

    m_axis_ex #(
        .C_M_AXIS_TDATA_WIDTH(8),
        .C_M_START_COUNT(8),
        .C_M_LINE_LEN(1),
        .C_M_LINES(1)
    ) u_min (
        .M_AXIS_ACLK(clk),
        .M_AXIS_ARESET(rst),
        .M_AXIS(axis_min.master)
    );

    assign axis_min.tready = axis.tready;

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        checks++;
        if (got !== exp) begin
            failures++;
            $display("FAIL %s: got %0h expected %0h (t=%0t)", tag, got, exp, $time);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic check_idle_outputs(input string tag);
        check({tag, "_tvalid"}, 32'(axis.tvalid), 32'd0);
        check({tag, "_tdata"},  32'(axis.tdata),  32'd0);
        check({tag, "_tstrb"},  32'(axis.tstrb),  32'd0);
        check({tag, "_tlast"},  32'(axis.tlast),  32'd0);
        check({tag, "_tuser"},  32'(axis.tuser),  32'd0);
        check({tag, "_min_tvalid"}, 32'(axis_min.tvalid), 32'd0);
        check({tag, "_min_tuser"},  32'(axis_min.tuser),  32'd0);
        check({tag, "_min_tlast"},  32'(axis_min.tlast),  32'd0);
    endtask

    // Expected beat b on the main DUT; the 1x1 instance always shows beat 0 with both flags.
    task automatic check_beat(input int b);
        check("tvalid", 32'(axis.tvalid), 32'd1);
        check("tdata",  32'(axis.tdata),  32'(b % 256));
        check("tstrb",  32'(axis.tstrb),  32'd1);
        check("tlast",  32'(axis.tlast),  32'(((b + 1) % 8) == 0));
        check("tuser",  32'(axis.tuser),  32'(b == 0));
        check("min_tvalid", 32'(axis_min.tvalid), 32'd1);
        check("min_tdata",  32'(axis_min.tdata),  32'd0);
        check("min_tlast",  32'(axis_min.tlast),  32'd1);
        check("min_tuser",  32'(axis_min.tuser),  32'd1);
    endtask

    task automatic step(input logic rdy);
        axis.tready = rdy;
        check_beat(exp_b);
        tick();
        if (rdy) exp_b = (exp_b + 1) % 32;
    endtask

    // Called #1 after an edge with reset high; releases it and checks the start delay.
    task automatic release_and_start(input bit toggle_ready);
        rst = 1'b0;
        for (int e = 1; e <= 8; e++) begin
            if (toggle_ready) axis.tready = e[0];
            tick();
            check("start_delay_tvalid", 32'(axis.tvalid), 32'd0);
            check("start_delay_min_tvalid", 32'(axis_min.tvalid), 32'd0);
        end
        axis.tready = 1'b0;
        tick();
        exp_b = 0;
        check_beat(0);
    endtask

    initial begin
        checks       = 0;
        failures     = 0;
        exp_b        = 0;
        rst          = 1'b1;
        axis.tready  = 1'b0;
        repeat (3) tick();
        check_idle_outputs("reset");

        // Start with TREADY low: first beat appears 9 edges after release and holds.
        release_and_start(1'b0);
        step(1'b0);
        step(1'b0);

        while (exp_b != 5) step(1'b1);
        repeat (10) step(1'b0);
        repeat (45) step(1'b1);

        while (exp_b != 20) step(1'b1);
        rst = 1'b1;
        #1;
        check_idle_outputs("async_reset");
        tick();
        check_idle_outputs("reset_held");
        release_and_start(1'b1);

        repeat (1100) step(1'b1);
        repeat (200) step(1'($urandom_range(0, 1)));
        repeat (40) step(1'b1);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL timeout: simulation did not complete (got running, expected finished)");
        $fatal(1, "timeout");
    end
endmodule

// File: doc/m_axis_ex.md
M_AXIS_EX -- requirements
Module: m_axis_ex

Interface
REQ-001 Parameter C_M_AXIS_TDATA_WIDTH, default 8, TDATA width in bits; SHALL be a multiple of 8.
REQ-002 Parameter C_M_START_COUNT, default 8, number of clock cycles waited after reset before streaming starts; SHALL be at least 1.
REQ-003 Parameter C_M_LINE_LEN, default 8, beats per line; SHALL be at least 1.
REQ-004 Parameter C_M_LINES, default 4, lines per frame; SHALL be at least 1.
REQ-005 M_AXIS_ACLK  in  1  single clock; all logic SHALL be on its rising edge.
REQ-006 M_AXIS_ARESET  in  1  reset; asynchronous, active-high.
REQ-007 M_AXIS_TVALID  out  1  beat valid.
REQ-008 M_AXIS_TDATA  out  C_M_AXIS_TDATA_WIDTH  beat payload.
REQ-009 M_AXIS_TSTRB  out  C_M_AXIS_TDATA_WIDTH/8  byte strobes.
REQ-010 M_AXIS_TLAST  out  1  last beat of a line (end of line).
REQ-011 M_AXIS_TUSER  out  1  first beat of a frame (start of frame).
REQ-012 M_AXIS_TREADY  in  1  downstream ready.

Function
REQ-013 The FSM SHALL have states IDLE, INIT_COUNTER and SEND_STREAM.
REQ-014 IDLE SHALL move to INIT_COUNTER on the first clock edge after reset release.
REQ-015 INIT_COUNTER SHALL count C_M_START_COUNT cycles, then move to SEND_STREAM, where it SHALL remain until reset.
REQ-016 M_AXIS_TVALID SHALL be registered and asserted from the first cycle in SEND_STREAM, then held continuously high.
REQ-017 A beat SHALL transfer only on a rising edge with TVALID=1 and TREADY=1; outputs advance only on a transfer.
REQ-018 While TVALID=1 and TREADY=0, TDATA, TLAST and TUSER SHALL be held stable.
REQ-019 A beat counter b (0..C_M_LINE_LEN*C_M_LINES-1) SHALL give TDATA = b modulo 2^C_M_AXIS_TDATA_WIDTH, zero-extended.
REQ-020 TUSER SHALL be 1 only when b=0.
REQ-021 TLAST SHALL be 1 when (b+1) mod C_M_LINE_LEN = 0.
REQ-022 After the beat with b = C_M_LINE_LEN*C_M_LINES-1 transfers, b SHALL wrap to 0, and the next frame SHALL start without gaps.
REQ-023 TSTRB SHALL be all ones whenever TVALID=1, and 0 otherwise.
REQ-024 TREADY changes before or during INIT_COUNTER SHALL NOT affect the start timing.
REQ-025 With C_M_LINE_LEN=1, TLAST SHALL be 1 on every beat.
REQ-026 With C_M_LINE_LEN*C_M_LINES=1, TUSER and TLAST SHALL both be 1 on every beat.

Reset
REQ-027 Asserting M_AXIS_ARESET SHALL immediately force: state IDLE, counters 0, TVALID=0, TDATA=0, TSTRB=0, TLAST=0, TUSER=0.
REQ-028 Reset asserted mid-frame SHALL abandon the frame; after release, the start delay SHALL repeat and streaming SHALL resume at b=0 with TUSER=1.

Verification
REQ-029 Release reset with TREADY=0 for 10 cycles -> TVALID rises C_M_START_COUNT+1 (=9) edges after release; first beat TDATA=0, TUSER=1 and held while TREADY=0.
REQ-030 TREADY=1 continuously -> TDATA 0,1,...,31,0,...; TLAST on 7, 15, 23, 31; TUSER on 0 only; one beat per cycle.
REQ-031 Drop TREADY for 10 cycles mid-line (at TDATA=5) -> TDATA stays 5 and TVALID stays 1; on resume the next value is 6, with no skipped or duplicated beat.
REQ-032 Assert reset for 1 cycle at TDATA=20 -> all outputs are 0 asynchronously; after release and a 9-cycle delay, the stream restarts at 0 with TUSER=1.
REQ-033 Run 1000+ cycles with TREADY=1 -> every 32nd transferred beat has TUSER=1; TSTRB=1 whenever TVALID=1.
REQ-034 Parameters C_M_LINE_LEN=1, C_M_LINES=1 -> every beat has TUSER=1, TLAST=1, TDATA=0.
